// File: rtl/test_pattern_pkg.sv
// Shared types and constants for the test pattern generator.
// The optional automatic pattern cycling is enabled by defining
// TEST_PATTERN_AUTO_CYCLE_EN when building test_pattern_gen.
package test_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_BARS     = 2'd0,
        MODE_CHECKER  = 2'd1,
        MODE_GRADIENT = 2'd2,
        MODE_BOX      = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } dir_t;

    localparam logic [23:0] COLOUR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COLOUR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] COLOUR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] COLOUR_GREEN   = 24'h00FF00;
    localparam logic [23:0] COLOUR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COLOUR_RED     = 24'hFF0000;
    localparam logic [23:0] COLOUR_BLUE    = 24'h0000FF;
    localparam logic [23:0] COLOUR_BLACK   = 24'h000000;

    localparam logic [23:0] BOX_FOREGROUND = 24'hFFFFFF;
    localparam logic [23:0] BOX_BACKGROUND = 24'h000040;

    localparam int PIPELINE_LATENCY = 2;

    // Colour of each of the eight vertical bars, left to right.
    function automatic logic [23:0] bar_colour(input logic [2:0] index);
        case (index)
            3'd0:    return COLOUR_WHITE;
            3'd1:    return COLOUR_YELLOW;
            3'd2:    return COLOUR_CYAN;
            3'd3:    return COLOUR_GREEN;
            3'd4:    return COLOUR_MAGENTA;
            3'd5:    return COLOUR_RED;
            3'd6:    return COLOUR_BLUE;
            default: return COLOUR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/test_pattern_gen_box_mover.sv
// Bouncing box position for the box pattern. Each axis steps by one pixel
// per frame start and bounces between 0 and RES-BOX_SIZE, resting on the
// limit for the frame in which it reverses.
module pattern_box_mover
    import test_pattern_pkg::*;
#(
    parameter int H_RESOLUTION = 640,
    parameter int V_RESOLUTION = 480,
    parameter int BOX_SIZE     = 32
) (
    input  logic                i_pixel_clk,
    input  logic                i_reset,
    input  logic                i_frame_start,
    output logic signed [12:0]  box_x,
    output logic signed [12:0]  box_y
);

    localparam logic signed [12:0] X_LIMIT = 13'(H_RESOLUTION - BOX_SIZE);
    localparam logic signed [12:0] Y_LIMIT = 13'(V_RESOLUTION - BOX_SIZE);

    dir_t x_dir;
    dir_t y_dir;

    // Step both axes once per frame, reversing in place at either limit.
    always_ff @(posedge i_pixel_clk or posedge i_reset) begin
        if (i_reset) begin
            box_x <= 13'sd0;
            box_y <= 13'sd0;
            x_dir <= DIR_INC;
            y_dir <= DIR_INC;
        end else if (i_frame_start) begin
            if (x_dir == DIR_INC) begin
                if (box_x >= X_LIMIT) x_dir <= DIR_DEC;
                else                  box_x <= box_x + 13'sd1;
            end else begin
                if (box_x <= 13'sd0)  x_dir <= DIR_INC;
                else                  box_x <= box_x - 13'sd1;
            end
            if (y_dir == DIR_INC) begin
                if (box_y >= Y_LIMIT) y_dir <= DIR_DEC;
                else                  box_y <= box_y + 13'sd1;
            end else begin
                if (box_y <= 13'sd0)  y_dir <= DIR_INC;
                else                  box_y <= box_y - 13'sd1;
            end
        end
    end

endmodule

// File: rtl/test_pattern_gen.sv
// Test pattern generator: colours each pixel from the timing generator's
// coordinates with one of four patterns, two-cycle pipeline, syncs delayed
// to match. Define TEST_PATTERN_AUTO_CYCLE_EN to advance the pattern
// automatically every AUTO_CYCLE_FRAMES frames.
module test_pattern_gen
    import test_pattern_pkg::*;
#(
    parameter int H_RESOLUTION      = 640,
    parameter int V_RESOLUTION      = 480,
    parameter int H_SYNC_POLARITY   = 0,
    parameter int V_SYNC_POLARITY   = 0,
    parameter int BOX_SIZE          = 32,
    parameter int AUTO_CYCLE_FRAMES = 120
) (
    input  logic                i_pixel_clk,
    input  logic                i_reset,
    input  logic [2:0]          i_hvesync,
    input  logic                i_frame_start,
    input  logic signed [12:0]  i_x,
    input  logic signed [12:0]  i_y,
    input  logic                i_mode_next,
    output logic [2:0]          o_hvesync,
    output logic [23:0]         o_rgb,
    output logic [1:0]          o_mode
);

    localparam logic [12:0]        BAR_LAST = 13'(H_RESOLUTION / 8 - 1);
    localparam logic signed [12:0] BOX_EDGE = 13'(BOX_SIZE);
    localparam logic [2:0] HVESYNC_IDLE = {1'b0,
                                           (V_SYNC_POLARITY != 0) ? 1'b0 : 1'b1,
                                           (H_SYNC_POLARITY != 0) ? 1'b0 : 1'b1};

    mode_t             mode_q;
    logic              mode_pending_q;
    logic [7:0]        frame_cnt_q;
    logic              auto_hit;
    logic signed [12:0] box_x;
    logic signed [12:0] box_y;

    logic [2:0]        hv_pipe [PIPELINE_LATENCY];
    logic [2:0]        bar_idx_s1;
    logic [12:0]       bar_cnt_s1;
    logic              checker_s1;
    logic [7:0]        grad_r_s1;
    logic [7:0]        grad_g_s1;
    logic              in_box_s1;

    logic [2:0]        bar_idx_next;
    logic [12:0]       bar_cnt_next;
    logic              in_box;
    logic [23:0]       colour_next;
    logic [23:0]       rgb_q;

    pattern_box_mover #(
        .H_RESOLUTION (H_RESOLUTION),
        .V_RESOLUTION (V_RESOLUTION),
        .BOX_SIZE     (BOX_SIZE)
    ) u_box_mover (
        .i_pixel_clk   (i_pixel_clk),
        .i_reset       (i_reset),
        .i_frame_start (i_frame_start),
        .box_x         (box_x),
        .box_y         (box_y)
    );

`ifdef TEST_PATTERN_AUTO_CYCLE_EN
    localparam int AUTO_W = (AUTO_CYCLE_FRAMES > 1) ? $clog2(AUTO_CYCLE_FRAMES) : 1;
    logic [AUTO_W-1:0] auto_cnt_q;

    assign auto_hit = i_frame_start && (auto_cnt_q == AUTO_W'(AUTO_CYCLE_FRAMES - 1));

    // Count frame starts and reload once the auto-advance point is reached.
    always_ff @(posedge i_pixel_clk or posedge i_reset) begin
        if (i_reset)            auto_cnt_q <= '0;
        else if (i_frame_start) auto_cnt_q <= auto_hit ? '0 : auto_cnt_q + 1'b1;
    end
`else
    assign auto_hit = 1'b0;
`endif

    // Mode changes only at frame start so a frame is never split between patterns.
    always_ff @(posedge i_pixel_clk or posedge i_reset) begin
        if (i_reset) begin
            mode_q         <= MODE_BARS;
            mode_pending_q <= 1'b0;
            frame_cnt_q    <= 8'd0;
        end else if (i_frame_start) begin
            frame_cnt_q    <= frame_cnt_q + 8'd1;
            mode_pending_q <= 1'b0;
            if (mode_pending_q || i_mode_next || auto_hit)
                mode_q <= mode_t'(mode_q + 2'd1);
        end else if (i_mode_next) begin
            mode_pending_q <= 1'b1;
        end
    end

    // Bar position tracked by counting pixels from x==0 instead of dividing.
    always_comb begin
        bar_idx_next = bar_idx_s1;
        bar_cnt_next = bar_cnt_s1 + 13'd1;
        if (i_x == 13'sd0) begin
            bar_idx_next = 3'd0;
            bar_cnt_next = 13'd0;
        end else if (bar_cnt_s1 == BAR_LAST) begin
            bar_cnt_next = 13'd0;
            if (bar_idx_s1 != 3'd7) bar_idx_next = bar_idx_s1 + 3'd1;
        end
    end

    assign in_box = (i_x >= box_x) && (i_x < box_x + BOX_EDGE) &&
                    (i_y >= box_y) && (i_y < box_y + BOX_EDGE);

    // Stage 1: capture the pixel and reduce it to per-pattern select terms.
    always_ff @(posedge i_pixel_clk or posedge i_reset) begin
        if (i_reset) begin
            bar_idx_s1 <= 3'd0;
            bar_cnt_s1 <= 13'd0;
            checker_s1 <= 1'b0;
            grad_r_s1  <= 8'd0;
            grad_g_s1  <= 8'd0;
            in_box_s1  <= 1'b0;
        end else begin
            bar_idx_s1 <= bar_idx_next;
            bar_cnt_s1 <= bar_cnt_next;
            checker_s1 <= i_x[5] ^ i_y[5];
            grad_r_s1  <= i_x[7:0];
            grad_g_s1  <= i_y[7:0];
            in_box_s1  <= in_box;
        end
    end

    // Sync bundle delay line, one entry per pipeline stage.
    always_ff @(posedge i_pixel_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < PIPELINE_LATENCY; i++) hv_pipe[i] <= HVESYNC_IDLE;
        end else begin
            hv_pipe[0] <= i_hvesync;
            for (int i = 1; i < PIPELINE_LATENCY; i++) hv_pipe[i] <= hv_pipe[i-1];
        end
    end

    // Final colour selection, forced black outside the active area.
    always_comb begin
        colour_next = COLOUR_BLACK;
        if (hv_pipe[0][2]) begin
            case (mode_q)
                MODE_BARS:     colour_next = bar_colour(bar_idx_s1);
                MODE_CHECKER:  colour_next = checker_s1 ? COLOUR_WHITE : COLOUR_BLACK;
                MODE_GRADIENT: colour_next = {grad_r_s1, grad_g_s1, frame_cnt_q};
                MODE_BOX:      colour_next = in_box_s1 ? BOX_FOREGROUND : BOX_BACKGROUND;
                default:       colour_next = COLOUR_BLACK;
            endcase
        end
    end

    // Stage 2: register the colour so it lines up with the delayed syncs.
    always_ff @(posedge i_pixel_clk or posedge i_reset) begin
        if (i_reset) rgb_q <= 24'h000000;
        else         rgb_q <= colour_next;
    end

    assign o_rgb     = rgb_q;
    assign o_hvesync = hv_pipe[PIPELINE_LATENCY-1];
    assign o_mode    = mode_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed self-checking bench for test_pattern_gen. Inputs change on the
// falling edge; outputs are read on the falling edge, two cycles after the
// pixel that produced them.
module tb_test_pattern_gen;

`ifdef TEST_PATTERN_AUTO_CYCLE_EN
    localparam int AUTO_FRAMES = 2;
`else
    localparam int AUTO_FRAMES = 120;
`endif

    logic               clk = 1'b0;
    logic               i_reset;
    logic [2:0]         i_hvesync;
    logic               i_frame_start;
    logic signed [12:0] i_x;
    logic signed [12:0] i_y;
    logic               i_mode_next;
    logic [2:0]         o_hvesync;
    logic [23:0]        o_rgb;
    logic [1:0]         o_mode;

    int checks   = 0;
    int failures = 0;

    test_pattern_gen #(
        .H_RESOLUTION      (640),
        .V_RESOLUTION      (480),
        .H_SYNC_POLARITY   (0),
        .V_SYNC_POLARITY   (0),
        .BOX_SIZE          (32),
        .AUTO_CYCLE_FRAMES (AUTO_FRAMES)
    ) dut (
        .i_pixel_clk   (clk),
        .i_reset       (i_reset),
        .i_hvesync     (i_hvesync),
        .i_frame_start (i_frame_start),
        .i_x           (i_x),
        .i_y           (i_y),
        .i_mode_next   (i_mode_next),
        .o_hvesync     (o_hvesync),
        .o_rgb         (o_rgb),
        .o_mode        (o_mode)
    );

    always #5 clk = ~clk;

    // One pixel-clock cycle of stimulus.
    task automatic drive(input logic signed [12:0] x, input logic signed [12:0] y,
                         input logic de, input logic fs, input logic mn);
        @(negedge clk);
        i_x           = x;
        i_y           = y;
        i_hvesync     = de ? 3'b111 : 3'b011;
        i_frame_start = fs;
        i_mode_next   = mn;
    endtask

    task automatic blank();
        drive(-13'sd1, -13'sd1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            drive(-13'sd1, -13'sd1, 1'b0, 1'b1, 1'b0);
            blank();
        end
    endtask

    // Present one pixel and return the colour that emerges two cycles later.
    task automatic probe(input logic signed [12:0] x, input logic signed [12:0] y,
                         input logic de, output logic [23:0] rgb);
        drive(x, y, de, 1'b0, 1'b0);
        blank();
        blank();
        rgb = o_rgb;
    endtask

    task automatic test_reset();
        blank();
        blank();
        checks++; if (o_rgb !== 24'h000000) begin failures++; $display("[TB] FAIL reset_rgb: got %h expected 000000", o_rgb); end
        checks++; if (o_hvesync !== 3'b011) begin failures++; $display("[TB] FAIL reset_hvesync: got %b expected 011", o_hvesync); end
        checks++; if (o_mode !== 2'd0) begin failures++; $display("[TB] FAIL reset_mode: got %0d expected 0", o_mode); end
        i_reset = 1'b0;
        for (int i = 0; i < 10; i++) drive(13'(i), 13'sd0, 1'b1, 1'b0, 1'b0);
        checks++; if (o_rgb !== 24'hFFFFFF) begin failures++; $display("[TB] FAIL pre_reset_white: got %h expected FFFFFF", o_rgb); end
        @(posedge clk);
        #2;
        i_reset = 1'b1;
        #1;
        checks++; if (o_rgb !== 24'h000000) begin failures++; $display("[TB] FAIL async_reset_rgb: got %h expected 000000", o_rgb); end
        checks++; if (o_hvesync !== 3'b011) begin failures++; $display("[TB] FAIL async_reset_hvesync: got %b expected 011", o_hvesync); end
        drive(13'sd11, 13'sd0, 1'b1, 1'b0, 1'b0);
        drive(13'sd0, 13'sd0, 1'b1, 1'b0, 1'b0);
        i_reset = 1'b0;
        drive(13'sd1, 13'sd0, 1'b1, 1'b0, 1'b0);
        checks++; if (o_rgb !== 24'h000000) begin failures++; $display("[TB] FAIL release_plus1_rgb: got %h expected 000000", o_rgb); end
        checks++; if (o_hvesync !== 3'b011) begin failures++; $display("[TB] FAIL release_plus1_hvesync: got %b expected 011", o_hvesync); end
        drive(13'sd2, 13'sd0, 1'b1, 1'b0, 1'b0);
        checks++; if (o_rgb !== 24'hFFFFFF) begin failures++; $display("[TB] FAIL release_plus2_rgb: got %h expected FFFFFF", o_rgb); end
        checks++; if (o_hvesync !== 3'b111) begin failures++; $display("[TB] FAIL release_plus2_hvesync: got %b expected 111", o_hvesync); end
        checks++; if (o_mode !== 2'd0) begin failures++; $display("[TB] FAIL release_mode: got %0d expected 0", o_mode); end
        blank();
        blank();
    endtask

    task automatic test_bars();
        logic [23:0] expected;
        bit          do_check;
        for (int i = 0; i < 643; i++) begin
            if (i < 640) drive(13'(i), 13'sd0, 1'b1, 1'b0, 1'b0);
            else         blank();
            do_check = 1'b1;
            expected = 24'h000000;
            case (i - 2)
                79:      expected = 24'hFFFFFF;
                80:      expected = 24'hFFFF00;
                159:     expected = 24'hFFFF00;
                160:     expected = 24'h00FFFF;
                400:     expected = 24'hFF0000;
                480:     expected = 24'h0000FF;
                639:     expected = 24'h000000;
                640:     expected = 24'h000000;
                default: do_check = 1'b0;
            endcase
            if (do_check) begin
                checks++;
                if (o_rgb !== expected) begin
                    failures++;
                    $display("[TB] FAIL bars_x%0d: got %h expected %h", i - 2, o_rgb, expected);
                end
            end
            if (i - 2 == 80) begin
                checks++; if (o_hvesync !== 3'b111) begin failures++; $display("[TB] FAIL bars_hvesync_active: got %b expected 111", o_hvesync); end
            end
            if (i - 2 == 640) begin
                checks++; if (o_hvesync !== 3'b011) begin failures++; $display("[TB] FAIL bars_hvesync_blank: got %b expected 011", o_hvesync); end
            end
        end
    endtask

    task automatic test_checker();
        logic [23:0] rgb;
        probe(13'sd32, 13'sd0, 1'b1, rgb);
        checks++; if (rgb !== 24'hFFFFFF) begin failures++; $display("[TB] FAIL checker_32_0: got %h expected FFFFFF", rgb); end
        probe(13'sd32, 13'sd32, 1'b1, rgb);
        checks++; if (rgb !== 24'h000000) begin failures++; $display("[TB] FAIL checker_32_32: got %h expected 000000", rgb); end
        probe(13'sd0, 13'sd32, 1'b1, rgb);
        checks++; if (rgb !== 24'hFFFFFF) begin failures++; $display("[TB] FAIL checker_0_32: got %h expected FFFFFF", rgb); end
        probe(13'sd31, 13'sd31, 1'b1, rgb);
        checks++; if (rgb !== 24'h000000) begin failures++; $display("[TB] FAIL checker_31_31: got %h expected 000000", rgb); end
        probe(13'sd64, 13'sd0, 1'b1, rgb);
        checks++; if (rgb !== 24'h000000) begin failures++; $display("[TB] FAIL checker_64_0: got %h expected 000000", rgb); end
    endtask

    task automatic test_mode_next();
        for (int i = 0; i < 3; i++) begin
            drive(-13'sd1, -13'sd1, 1'b0, 1'b0, 1'b1);
            blank();
        end
        checks++; if (o_mode !== 2'd0) begin failures++; $display("[TB] FAIL mode_before_frame: got %0d expected 0", o_mode); end
        frame_pulses(1);
        checks++; if (o_mode !== 2'd1) begin failures++; $display("[TB] FAIL mode_after_frame: got %0d expected 1", o_mode); end
        test_checker();
        frame_pulses(1);
        checks++; if (o_mode !== 2'd1) begin failures++; $display("[TB] FAIL mode_no_request: got %0d expected 1", o_mode); end
        drive(-13'sd1, -13'sd1, 1'b0, 1'b1, 1'b1);
        blank();
        checks++; if (o_mode !== 2'd2) begin failures++; $display("[TB] FAIL mode_coincident: got %0d expected 2", o_mode); end
    endtask

    task automatic test_gradient();
        logic [23:0] rgb;
        frame_pulses(252);
        probe(13'sd300, 13'sd10, 1'b1, rgb);
        checks++; if (rgb !== 24'h2C0AFF) begin failures++; $display("[TB] FAIL gradient_cnt255: got %h expected 2C0AFF", rgb); end
        frame_pulses(1);
        probe(13'sd300, 13'sd10, 1'b1, rgb);
        checks++; if (rgb !== 24'h2C0A00) begin failures++; $display("[TB] FAIL gradient_wrap: got %h expected 2C0A00", rgb); end
        probe(13'sd5, 13'sd200, 1'b1, rgb);
        checks++; if (rgb !== 24'h05C800) begin failures++; $display("[TB] FAIL gradient_5_200: got %h expected 05C800", rgb); end
        checks++; if (o_mode !== 2'd2) begin failures++; $display("[TB] FAIL gradient_mode: got %0d expected 2", o_mode); end
    endtask

    task automatic test_box();
        logic [23:0] rgb;
        drive(-13'sd1, -13'sd1, 1'b0, 1'b0, 1'b1);
        frame_pulses(353);
        checks++; if (o_mode !== 2'd3) begin failures++; $display("[TB] FAIL box_mode: got %0d expected 3", o_mode); end
        probe(13'sd607, 13'sd288, 1'b1, rgb);
        checks++; if (rgb !== 24'h000040) begin failures++; $display("[TB] FAIL box_607_288: got %h expected 000040", rgb); end
        probe(13'sd608, 13'sd288, 1'b1, rgb);
        checks++; if (rgb !== 24'hFFFFFF) begin failures++; $display("[TB] FAIL box_608_288: got %h expected FFFFFF", rgb); end
        probe(13'sd639, 13'sd288, 1'b1, rgb);
        checks++; if (rgb !== 24'hFFFFFF) begin failures++; $display("[TB] FAIL box_639_288: got %h expected FFFFFF", rgb); end
        probe(13'sd620, 13'sd319, 1'b1, rgb);
        checks++; if (rgb !== 24'hFFFFFF) begin failures++; $display("[TB] FAIL box_620_319: got %h expected FFFFFF", rgb); end
        probe(13'sd620, 13'sd320, 1'b1, rgb);
        checks++; if (rgb !== 24'h000040) begin failures++; $display("[TB] FAIL box_620_320: got %h expected 000040", rgb); end
        probe(13'sd620, 13'sd300, 1'b0, rgb);
        checks++; if (rgb !== 24'h000000) begin failures++; $display("[TB] FAIL box_blanking: got %h expected 000000", rgb); end
        frame_pulses(1);
        probe(13'sd607, 13'sd287, 1'b1, rgb);
        checks++; if (rgb !== 24'hFFFFFF) begin failures++; $display("[TB] FAIL box_607_287: got %h expected FFFFFF", rgb); end
        probe(13'sd639, 13'sd287, 1'b1, rgb);
        checks++; if (rgb !== 24'h000040) begin failures++; $display("[TB] FAIL box_639_287: got %h expected 000040", rgb); end
        probe(13'sd606, 13'sd287, 1'b1, rgb);
        checks++; if (rgb !== 24'h000040) begin failures++; $display("[TB] FAIL box_606_287: got %h expected 000040", rgb); end
    endtask

    task automatic test_auto_cycle();
        logic [1:0] expected_modes [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        for (int p = 0; p < 8; p++) begin
            frame_pulses(1);
            checks++;
            if (o_mode !== expected_modes[p]) begin
                failures++;
                $display("[TB] FAIL auto_pulse%0d: got %0d expected %0d", p + 1, o_mode, expected_modes[p]);
            end
        end
        frame_pulses(1);
        drive(-13'sd1, -13'sd1, 1'b0, 1'b1, 1'b1);
        blank();
        checks++; if (o_mode !== 2'd1) begin failures++; $display("[TB] FAIL auto_coincident: got %0d expected 1", o_mode); end
        drive(-13'sd1, -13'sd1, 1'b0, 1'b0, 1'b1);
        frame_pulses(1);
        checks++; if (o_mode !== 2'd2) begin failures++; $display("[TB] FAIL auto_manual: got %0d expected 2", o_mode); end
        frame_pulses(1);
        checks++; if (o_mode !== 2'd3) begin failures++; $display("[TB] FAIL auto_after_manual: got %0d expected 3", o_mode); end
    endtask

    initial begin
        i_reset       = 1'b1;
        i_hvesync     = 3'b011;
        i_frame_start = 1'b0;
        i_x           = -13'sd1;
        i_y           = -13'sd1;
        i_mode_next   = 1'b0;
        $display("[TB] starting test_pattern_gen bench");
        test_reset();
`ifdef TEST_PATTERN_AUTO_CYCLE_EN
        test_auto_cycle();
`else
        test_bars();
        test_mode_next();
        test_gradient();
        test_box();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
